// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch-stage program-counter generator.
package pc_gen_pkg;

  typedef enum logic {S_BOOT, S_RUN} state_e;

  typedef enum logic [1:0] {PK_NONE, PK_BR, PK_TRAP} pend_kind_e;

  localparam int unsigned PC_INC_DEFAULT = 4;
  localparam int unsigned INC_LSB        = $clog2(PC_INC_DEFAULT);

  // Clears the low inc_lsb bits so a redirect can never land mid-instruction.
  function automatic logic [63:0] align_pc(input logic [63:0] pc, input int unsigned inc_lsb);
    logic [63:0] mask;
    mask = ~((64'd1 << inc_lsb) - 64'd1);
    return pc & mask;
  endfunction

endpackage

// File: rtl/pc_redirect_latch.sv
// Holds one redirect or trap that arrived during a stall until the PC may be written.
module pc_redirect_latch
  import pc_gen_pkg::*;
#(
  parameter int unsigned           PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]   TRAP_VECTOR = PC_WIDTH'(32'h80)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_i,
  input  logic                clear_i,
  input  logic                trap_i,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] target_i,
  output logic                pend_valid_o,
  output pend_kind_e          pend_kind_o,
  output logic [PC_WIDTH-1:0] pend_target_o
);

  pend_kind_e          kind_q, kind_d;
  logic [PC_WIDTH-1:0] target_q, target_d;

  // A buffered trap is sticky against later redirects; a newer branch replaces an older one.
  always_comb begin
    kind_d   = kind_q;
    target_d = target_q;
    if (clear_i) begin
      kind_d   = PK_NONE;
      target_d = '0;
    end else if (stall_i) begin
      if (trap_i) begin
        kind_d   = PK_TRAP;
        target_d = TRAP_VECTOR;
      end else if (redirect_i && (kind_q != PK_TRAP)) begin
        kind_d   = PK_BR;
        target_d = target_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kind_q   <= PK_NONE;
      target_q <= '0;
    end else begin
      kind_q   <= kind_d;
      target_q <= target_d;
    end
  end

  assign pend_valid_o  = (kind_q != PK_NONE);
  assign pend_kind_o   = kind_q;
  assign pend_target_o = target_q;

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch program counter: boot sequencing, stall handling and redirect/trap selection.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int unsigned         PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = PC_WIDTH'(32'h80),
  parameter int unsigned         PC_INC       = 4,
  parameter int unsigned         BOOT_CYCLES  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pc_write,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  input  logic                trap_valid,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [PC_WIDTH-1:0] pc_plus_inc,
  output logic                pc_valid,
  output logic                redirect_pending
);

  localparam int unsigned       PC_INC_LSB = $clog2(PC_INC);
  localparam int unsigned       CNT_W      = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(BOOT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] target_aligned;
  logic                run, boot_done;
  logic                pend_valid;
  pend_kind_e          pend_kind;
  logic [PC_WIDTH-1:0] pend_target;

  assign run       = (state_q == S_RUN);
  assign boot_done = (state_q == S_BOOT) && (cnt_q == CNT_LAST);

  assign target_aligned = PC_WIDTH'(align_pc(64'(redirect_target), PC_INC_LSB));
  assign pc_plus_inc    = pc_q + PC_WIDTH'(PC_INC);

  pc_redirect_latch #(
    .PC_WIDTH    (PC_WIDTH),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_latch (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (run && !pc_write),
    .clear_i       (run && pc_write),
    .trap_i        (trap_valid),
    .redirect_i    (redirect_valid),
    .target_i      (target_aligned),
    .pend_valid_o  (pend_valid),
    .pend_kind_o   (pend_kind),
    .pend_target_o (pend_target)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      cnt_q   <= '0;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  if (boot_done) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  // Counter saturates on its last value; the state change makes further counting moot.
  always_comb begin
    cnt_d = cnt_q;
    pc_d  = pc_q;
    if ((state_q == S_BOOT) && !boot_done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (run && pc_write) begin
      if (trap_valid)          pc_d = TRAP_VECTOR;
      else if (redirect_valid) pc_d = target_aligned;
      else if (pend_valid)     pc_d = pend_target;
      else                     pc_d = pc_plus_inc;
    end
  end

  assign pc_out           = pc_q;
  assign pc_valid         = run;
  assign redirect_pending = pend_valid && (pend_kind != PK_NONE);

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed scoreboard bench for pc_gen_unit with BOOT_CYCLES=2.
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_inc;
  logic        pc_valid;
  logic        redirect_pending;

  int total = 0;
  int bad   = 0;
  bit stim_done = 1'b0;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic        v;
    logic        p;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  pc_gen_unit #(
    .PC_WIDTH     (32),
    .RESET_VECTOR (32'h0),
    .TRAP_VECTOR  (32'h80),
    .PC_INC       (4),
    .BOOT_CYCLES  (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_write         (pc_write),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .trap_valid       (trap_valid),
    .pc_out           (pc_out),
    .pc_plus_inc      (pc_plus_inc),
    .pc_valid         (pc_valid),
    .redirect_pending (redirect_pending)
  );

  // One clock of stimulus; the expected post-edge state goes to the scoreboard.
  task automatic cyc(input string nm, input logic rn, input logic pw, input logic rv,
                     input logic [31:0] rt, input logic tv,
                     input logic [31:0] epc, input logic ev, input logic ep);
    exp_t e;
    rst_n = rn; pc_write = pw; redirect_valid = rv; redirect_target = rt; trap_valid = tv;
    @(posedge clk);
    #1;
    e.nm = nm; e.pc = epc; e.v = ev; e.p = ep;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: compares the DUT against whatever the stimulus queued for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.nm, ".pc"},      pc_out,                    e.pc);
      chk({e.nm, ".inc"},     pc_plus_inc,               e.pc + 32'd4);
      chk({e.nm, ".valid"},   {31'd0, pc_valid},         {31'd0, e.v});
      chk({e.nm, ".pending"}, {31'd0, redirect_pending}, {31'd0, e.p});
      $display("txn %-10s pc=%h inc=%h valid=%0b pend=%0b", e.nm, pc_out, pc_plus_inc,
               pc_valid, redirect_pending);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; pc_write = 1'b0; redirect_valid = 1'b0; redirect_target = '0; trap_valid = 1'b0;

    // 1: reset, two boot edges, then sequential fetch from 0 (boot ignores a trap)
    for (int i = 0; i < 3; i++) cyc("rst", 0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
    cyc("boot1", 1, 1, 0, 32'h0, 1, 32'h0, 0, 0);
    cyc("boot2", 1, 1, 1, 32'h500, 0, 32'h0, 1, 0);
    cyc("seq4",  1, 1, 0, 32'h0, 0, 32'h4,  1, 0);
    cyc("seq8",  1, 1, 0, 32'h0, 0, 32'h8,  1, 0);
    cyc("seq12", 1, 1, 0, 32'h0, 0, 32'hC,  1, 0);
    cyc("seq16", 1, 1, 0, 32'h0, 0, 32'h10, 1, 0);

    // 2: plain stall holds, release advances
    for (int i = 0; i < 3; i++) cyc("stall", 1, 0, 0, 32'h0, 0, 32'h10, 1, 0);
    cyc("unstall", 1, 1, 0, 32'h0, 0, 32'h14, 1, 0);

    // 3: newer branch overwrites older while stalled; low bits are aligned away
    cyc("br103", 1, 0, 1, 32'h103, 0, 32'h14,  1, 1);
    cyc("br200", 1, 0, 1, 32'h200, 0, 32'h14,  1, 1);
    cyc("brtake", 1, 1, 0, 32'h0,  0, 32'h200, 1, 0);
    cyc("br103b", 1, 0, 1, 32'h103, 0, 32'h200, 1, 1);
    cyc("align",  1, 1, 0, 32'h0,  0, 32'h100, 1, 0);

    // live redirect beats a buffered one
    cyc("br600", 1, 0, 1, 32'h600, 0, 32'h100, 1, 1);
    cyc("br700", 1, 1, 1, 32'h700, 0, 32'h700, 1, 0);

    // 4: simultaneous trap+redirect, then trap buffered ahead of a later redirect
    cyc("trapnow", 1, 1, 1, 32'h400, 1, 32'h80, 1, 0);
    cyc("seq84",   1, 1, 0, 32'h0,   0, 32'h84, 1, 0);
    cyc("trapbuf", 1, 0, 0, 32'h0,   1, 32'h84, 1, 1);
    cyc("brlost",  1, 0, 1, 32'h500, 0, 32'h84, 1, 1);
    cyc("traptake", 1, 1, 0, 32'h0,  0, 32'h80, 1, 0);
    cyc("seq84b",  1, 1, 0, 32'h0,   0, 32'h84, 1, 0);

    // 5: wrap-around at the top of the address space
    cyc("brtop", 1, 1, 1, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 1, 0);
    cyc("wrap",  1, 1, 0, 32'h0,         0, 32'h0,         1, 0);

    // 6: reset with a branch pending discards it
    cyc("seq4b",  1, 1, 0, 32'h0,   0, 32'h4, 1, 0);
    cyc("br300",  1, 0, 1, 32'h300, 0, 32'h4, 1, 1);
    cyc("rst2",   0, 0, 1, 32'h300, 0, 32'h0, 0, 0);
    cyc("boot1b", 1, 1, 0, 32'h0,   0, 32'h0, 0, 0);
    cyc("boot2b", 1, 1, 0, 32'h0,   0, 32'h0, 1, 0);
    cyc("post",   1, 1, 0, 32'h0,   0, 32'h4, 1, 0);

    stim_done = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
